// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, scoreboard entry layout and select encodings
//
// Purpose: common definitions for the hazard/forwarding unit and its users.
// Contents:
//   REG_W             default register-address width
//   EF_*              bit offsets of the fields inside a flattened scoreboard entry
//   entry_w()         width of one flattened entry for a given register width
//   sel_w()           forwarding select width for a given number of tracked stages
//   sb_entry_t        scoreboard entry {valid, rd, we, is_load} at the default REG_W
//   SEL_*             forwarding select encodings for the 5-stage pipe
package cpu_pkg;

    localparam int REG_W = 5;

    // Flattened entry layout, LSB first: is_load, we, rd[REG_W], valid.
    // Matches the packed order of sb_entry_t.
    localparam int EF_LOAD = 0;
    localparam int EF_WE   = 1;
    localparam int EF_RD   = 2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } sb_entry_t;

    localparam int SEL_RF  = 0;
    localparam int SEL_EX  = 1;
    localparam int SEL_MEM = 2;
    localparam int SEL_WB  = 3;

    function automatic int entry_w(input int reg_w);
        return reg_w + 3;
    endfunction

    function automatic int sel_w(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - per-source priority match against the scoreboard
//
// Purpose: find the youngest in-flight producer of one source register and
// turn it into a forwarding select or a load-use stall request.
// Ports:
//   rs         in   REG_W                  source register address
//   rs_used    in   1                      source is actually read
//   sb         in   FWD_STAGES*(REG_W+3)   flattened scoreboard, entry i = stage i
//   fwd_sel    out  SEL_W                  0 = regfile, i+1 = forward from stage i
//   stall_req  out  1                      youngest producer is a load not yet forwardable
module hazard_src_match
    import cpu_pkg::*;
#(
    parameter int REG_W      = cpu_pkg::REG_W,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = sel_w(FWD_STAGES)
) (
    input  logic [REG_W-1:0]                   rs,
    input  logic                               rs_used,
    input  logic [FWD_STAGES*(REG_W+3)-1:0]    sb,
    output logic [SEL_W-1:0]                   fwd_sel,
    output logic                               stall_req
);

    localparam int EW = entry_w(REG_W);

    logic [EW-1:0] ent;
    logic          found;

    // Stage 0 is scanned first so the youngest producer wins; once found,
    // older entries are ignored even if they also match.
    always_comb begin
        fwd_sel   = '0;
        stall_req = 1'b0;
        found     = 1'b0;
        ent       = '0;
        for (int i = 0; i < FWD_STAGES; i++) begin
            ent = sb[i*EW +: EW];
            if (!found && ent[EW-1] && ent[EF_WE] && (ent[EF_RD +: REG_W] == rs)
                && (rs != '0) && rs_used) begin
                found = 1'b1;
                if (ent[EF_LOAD] && (i < LOAD_LAT)) begin
                    stall_req = 1'b1;
                end else begin
                    fwd_sel = SEL_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_unit_pipe.sv
// rtl/hazard_unit_pipe.sv - hazard/forwarding unit beside the ID stage
//
// Purpose: tracks in-flight destinations in a shift-register scoreboard and
// produces forwarding selects, load-use stalls, branch flush masks and a
// saturating stall counter.
// Ports:
//   clk, reset     in   clock, synchronous active-high reset
//   id_valid       in   ID holds a valid instruction
//   id_rs          in   NUM_SRC*REG_W source registers, source k at [k*REG_W +: REG_W]
//   id_rs_used     in   NUM_SRC per-source read enables
//   id_rd          in   destination register
//   id_rd_we       in   instruction writes rd
//   id_is_load     in   instruction is a load
//   took_branch    in   taken branch/jump resolved this cycle
//   ext_stall      in   whole-pipe freeze
//   fwd_sel        out  NUM_SRC*SEL_W per-source forwarding select
//   stop_ID        out  hold PC/ID and inject a bubble into EX
//   set_invalid    out  FLUSH_DEPTH flush mask, bit 0 = ID, bit i = stage i-1
//   stall_cnt      out  CNT_W saturating load-use stall cycle count
module hazard_unit_pipe
    import cpu_pkg::*;
#(
    parameter int REG_W       = cpu_pkg::REG_W,
    parameter int NUM_SRC     = 2,
    parameter int FWD_STAGES  = 3,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = 16,
    localparam int SEL_W      = sel_w(FWD_STAGES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]         id_rs_used,
    input  logic [REG_W-1:0]           id_rd,
    input  logic                       id_rd_we,
    input  logic                       id_is_load,
    input  logic                       took_branch,
    input  logic                       ext_stall,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stop_ID,
    output logic [FLUSH_DEPTH-1:0]     set_invalid,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int EW = entry_w(REG_W);

    logic [EW-1:0]              sb [FWD_STAGES];
    logic [FWD_STAGES*EW-1:0]   sb_flat;
    logic [NUM_SRC*SEL_W-1:0]   raw_sel;
    logic [NUM_SRC-1:0]         stall_req;
    logic [EW-1:0]              id_entry;
    logic                       take_id;

    for (genvar g = 0; g < FWD_STAGES; g++) begin : g_flat
        assign sb_flat[g*EW +: EW] = sb[g];
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_src_match #(
            .REG_W      (REG_W),
            .FWD_STAGES (FWD_STAGES),
            .LOAD_LAT   (LOAD_LAT),
            .SEL_W      (SEL_W)
        ) u_match (
            .rs        (id_rs[k*REG_W +: REG_W]),
            .rs_used   (id_rs_used[k]),
            .sb        (sb_flat),
            .fwd_sel   (raw_sel[k*SEL_W +: SEL_W]),
            .stall_req (stall_req[k])
        );
    end

    // A taken branch kills the ID instruction anyway, so it must not stall.
    assign stop_ID     = !reset && !took_branch && (|stall_req);
    assign fwd_sel     = reset ? '0 : raw_sel;
    assign set_invalid = (!reset && took_branch) ? '1 : '0;

    assign id_entry = {1'b1, id_rd, id_rd_we, id_is_load};
    assign take_id  = id_valid && !stop_ID && !took_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FWD_STAGES; i++) begin
                sb[i] <= '0;
            end
            stall_cnt <= '0;
        end else if (!ext_stall) begin
            // Flushed stages beyond ID take a bubble instead of their predecessor.
            for (int i = FWD_STAGES - 1; i >= 1; i--) begin
                if (took_branch && (i < FLUSH_DEPTH - 1)) begin
                    sb[i] <= '0;
                end else begin
                    sb[i] <= sb[i-1];
                end
            end
            sb[0] <= take_id ? id_entry : '0;
            if (stop_ID && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit_pipe.sv
// tb/tb_hazard_unit_pipe.sv - self-checking bench for hazard_unit_pipe
module tb_hazard_unit_pipe;
    import cpu_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } instr_t;

    typedef struct packed {
        instr_t      ins;
        logic        br;
        logic [1:0]  f0;
        logic [1:0]  f1;
        logic        stop;
        logic [2:0]  inv;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_is_load;
    logic        took_branch;
    logic        ext_stall;

    logic [3:0]  fwd_sel;
    logic        stop_id;
    logic [2:0]  set_invalid;
    logic [15:0] stall_cnt;
    logic [3:0]  fwd_sel2;
    logic        stop_id2;
    logic [2:0]  set_invalid2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int failures = 0;

    logic [3:0]  s_fwd, s2_fwd;
    logic        s_stop, s2_stop;
    logic [2:0]  s_inv;
    logic [15:0] s_cnt;
    logic [1:0]  s2_cnt;

    sb_entry_t   pipe [$];
    int unsigned mdl_cnt;

    always #5 clk = ~clk;

    hazard_unit_pipe dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .took_branch(took_branch), .ext_stall(ext_stall),
        .fwd_sel(fwd_sel), .stop_ID(stop_id), .set_invalid(set_invalid),
        .stall_cnt(stall_cnt)
    );

    hazard_unit_pipe #(.LOAD_LAT(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .took_branch(took_branch), .ext_stall(ext_stall),
        .fwd_sel(fwd_sel2), .stop_ID(stop_id2), .set_invalid(set_invalid2),
        .stall_cnt(stall_cnt2)
    );

    function automatic instr_t mk(input logic v, input logic [4:0] a, input logic [4:0] b,
                                  input logic [1:0] u, input logic [4:0] d,
                                  input logic w, input logic l);
        instr_t r;
        r.valid = v; r.rs0 = a; r.rs1 = b; r.used = u; r.rd = d; r.we = w; r.ld = l;
        return r;
    endfunction

    function automatic instr_t alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        return mk(1'b1, a, b, 2'b11, d, 1'b1, 1'b0);
    endfunction

    function automatic instr_t lw(input logic [4:0] d, input logic [4:0] a);
        return mk(1'b1, a, 5'd0, 2'b01, d, 1'b1, 1'b1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb_entry_t bub;
        bub = '0;
        pipe = {};
        for (int a = 0; a < 3; a++) pipe.push_back(bub);
        mdl_cnt = 0;
    endtask

    // Expected outputs from the pipeline contents: for each source, the age of
    // the most recent in-flight writer decides regfile, forward or stall.
    task automatic model_eval(output logic [3:0] f, output logic st, output logic [2:0] inv);
        logic haz;
        logic [4:0] rs;
        int age;
        f = 4'd0; st = 1'b0; inv = 3'd0; haz = 1'b0;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                rs = (k == 0) ? id_rs[4:0] : id_rs[9:5];
                age = -1;
                if (id_rs_used[k] && rs != 5'd0) begin
                    for (int a = 0; a < 3; a++) begin
                        if (pipe[a].valid && pipe[a].we && pipe[a].rd == rs) begin
                            age = a;
                            break;
                        end
                    end
                end
                if (age >= 0) begin
                    if (pipe[age].is_load && age < 1) haz = 1'b1;
                    else f[k*2 +: 2] = 2'(age + 1);
                end
            end
            st = haz && !took_branch;
            inv = took_branch ? 3'b111 : 3'b000;
        end
    endtask

    task automatic model_step(input logic st);
        sb_entry_t nw;
        if (reset) begin
            model_reset();
        end else if (!ext_stall) begin
            if (st && mdl_cnt < 32'hFFFF) mdl_cnt++;
            nw = '0;
            if (id_valid && !st && !took_branch) begin
                nw.valid = 1'b1; nw.rd = id_rd; nw.we = id_rd_we; nw.is_load = id_is_load;
            end
            pipe.push_front(nw);
            void'(pipe.pop_back());
            if (took_branch) begin
                pipe[0] = '0;
                pipe[1] = '0;
            end
        end
    endtask

    task automatic drive(input logic rst, input instr_t ins, input logic br, input logic xs);
        reset = rst; id_valid = ins.valid; id_rs = {ins.rs1, ins.rs0};
        id_rs_used = ins.used; id_rd = ins.rd; id_rd_we = ins.we; id_is_load = ins.ld;
        took_branch = br; ext_stall = xs;
    endtask

    task automatic cycle(input logic rst, input instr_t ins, input logic br, input logic xs);
        logic [3:0] ef;
        logic es;
        logic [2:0] ei;
        drive(rst, ins, br, xs);
        @(negedge clk);
        model_eval(ef, es, ei);
        s_fwd = fwd_sel; s_stop = stop_id; s_inv = set_invalid; s_cnt = stall_cnt;
        s2_fwd = fwd_sel2; s2_stop = stop_id2; s2_cnt = stall_cnt2;
        chk("model fwd_sel", 32'(fwd_sel), 32'(ef));
        chk("model stop_ID", 32'(stop_id), 32'(es));
        chk("model set_invalid", 32'(set_invalid), 32'(ei));
        chk("model stall_cnt", 32'(stall_cnt), mdl_cnt);
        model_step(es);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [16];
    instr_t nop;
    instr_t dep;

    initial begin
        nop = mk(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        dep = alu(5'd8, 5'd7, 5'd7);

        vecs[0]  = '{alu(5'd5, 5'd1, 5'd2),   1'b0, 2'(SEL_RF),  2'(SEL_RF),  1'b0, 3'd0, 16'd0};
        vecs[1]  = '{alu(5'd6, 5'd5, 5'd1),   1'b0, 2'(SEL_EX),  2'(SEL_RF),  1'b0, 3'd0, 16'd0};
        vecs[2]  = '{alu(5'd10, 5'd5, 5'd0),  1'b0, 2'(SEL_MEM), 2'(SEL_RF),  1'b0, 3'd0, 16'd0};
        vecs[3]  = '{lw(5'd7, 5'd3),          1'b0, 2'(SEL_RF),  2'(SEL_RF),  1'b0, 3'd0, 16'd0};
        vecs[4]  = '{alu(5'd8, 5'd7, 5'd7),   1'b0, 2'(SEL_RF),  2'(SEL_RF),  1'b1, 3'd0, 16'd0};
        vecs[5]  = '{alu(5'd8, 5'd7, 5'd7),   1'b0, 2'(SEL_MEM), 2'(SEL_MEM), 1'b0, 3'd0, 16'd1};
        vecs[6]  = '{alu(5'd9, 5'd8, 5'd0),   1'b0, 2'(SEL_EX),  2'(SEL_RF),  1'b0, 3'd0, 16'd1};
        vecs[7]  = '{alu(5'd9, 5'd9, 5'd0),   1'b0, 2'(SEL_EX),  2'(SEL_RF),  1'b0, 3'd0, 16'd1};
        vecs[8]  = '{alu(5'd11, 5'd9, 5'd8),  1'b0, 2'(SEL_EX),  2'(SEL_WB),  1'b0, 3'd0, 16'd1};
        vecs[9]  = '{alu(5'd0, 5'd1, 5'd2),   1'b0, 2'(SEL_RF),  2'(SEL_RF),  1'b0, 3'd0, 16'd1};
        vecs[10] = '{alu(5'd12, 5'd0, 5'd0),  1'b0, 2'(SEL_RF),  2'(SEL_RF),  1'b0, 3'd0, 16'd1};
        vecs[11] = '{lw(5'd13, 5'd1),         1'b0, 2'(SEL_RF),  2'(SEL_RF),  1'b0, 3'd0, 16'd1};
        vecs[12] = '{mk(1'b1, 5'd13, 5'd13, 2'b00, 5'd14, 1'b1, 1'b0),
                                              1'b0, 2'(SEL_RF),  2'(SEL_RF),  1'b0, 3'd0, 16'd1};
        vecs[13] = '{lw(5'd15, 5'd1),         1'b0, 2'(SEL_RF),  2'(SEL_RF),  1'b0, 3'd0, 16'd1};
        vecs[14] = '{alu(5'd16, 5'd15, 5'd14),1'b1, 2'(SEL_RF),  2'(SEL_MEM), 1'b0, 3'd7, 16'd1};
        vecs[15] = '{alu(5'd17, 5'd15, 5'd14),1'b0, 2'(SEL_RF),  2'(SEL_WB),  1'b0, 3'd0, 16'd1};

        // Bring the registers out of X before the model starts tracking.
        drive(1'b1, nop, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        model_reset();

        // Reset cycle with a branch request: combinational outputs stay 0.
        cycle(1'b1, alu(5'd3, 5'd3, 5'd3), 1'b1, 1'b0);
        chk("reset fwd_sel", 32'(s_fwd), 32'd0);
        chk("reset stop_ID", 32'(s_stop), 32'd0);
        chk("reset set_invalid", 32'(s_inv), 32'd0);

        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, vecs[i].ins, vecs[i].br, 1'b0);
            chk($sformatf("vec%0d fwd0", i), 32'(s_fwd[1:0]), 32'(vecs[i].f0));
            chk($sformatf("vec%0d fwd1", i), 32'(s_fwd[3:2]), 32'(vecs[i].f1));
            chk($sformatf("vec%0d stop_ID", i), 32'(s_stop), 32'(vecs[i].stop));
            chk($sformatf("vec%0d set_invalid", i), 32'(s_inv), 32'(vecs[i].inv));
            chk($sformatf("vec%0d stall_cnt", i), 32'(s_cnt), 32'(vecs[i].cnt));
        end

        // ext_stall hold with a load in EX and its consumer in ID.
        cycle(1'b1, nop, 1'b0, 1'b0);
        cycle(1'b0, lw(5'd7, 5'd1), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, dep, 1'b0, 1'b1);
            chk($sformatf("xstall%0d stop_ID", i), 32'(s_stop), 32'd1);
            chk($sformatf("xstall%0d stall_cnt", i), 32'(s_cnt), 32'd0);
        end
        cycle(1'b0, dep, 1'b0, 1'b0);
        chk("xrelease stop_ID", 32'(s_stop), 32'd1);
        cycle(1'b0, dep, 1'b0, 1'b0);
        chk("xdone fwd_sel", 32'(s_fwd), 32'hA);
        chk("xdone stop_ID", 32'(s_stop), 32'd0);
        chk("xdone stall_cnt", 32'(s_cnt), 32'd1);

        // Reset in the middle of a load-use stall.
        cycle(1'b0, lw(5'd7, 5'd1), 1'b0, 1'b0);
        cycle(1'b0, dep, 1'b0, 1'b0);
        chk("pre-reset stop_ID", 32'(s_stop), 32'd1);
        cycle(1'b1, dep, 1'b1, 1'b0);
        chk("midreset fwd_sel", 32'(s_fwd), 32'd0);
        chk("midreset stop_ID", 32'(s_stop), 32'd0);
        chk("midreset set_invalid", 32'(s_inv), 32'd0);
        cycle(1'b0, dep, 1'b0, 1'b0);
        chk("postreset fwd_sel", 32'(s_fwd), 32'd0);
        chk("postreset stop_ID", 32'(s_stop), 32'd0);
        chk("postreset stall_cnt", 32'(s_cnt), 32'd0);

        // LOAD_LAT = 2 instance: two stall cycles, then forward from WB;
        // its 2-bit counter must saturate at 3.
        cycle(1'b1, nop, 1'b0, 1'b0);
        cycle(1'b0, lw(5'd7, 5'd1), 1'b0, 1'b0);
        cycle(1'b0, dep, 1'b0, 1'b0);
        chk("lat2 stall1", 32'(s2_stop), 32'd1);
        cycle(1'b0, dep, 1'b0, 1'b0);
        chk("lat2 stall2", 32'(s2_stop), 32'd1);
        cycle(1'b0, dep, 1'b0, 1'b0);
        chk("lat2 fwd stop_ID", 32'(s2_stop), 32'd0);
        chk("lat2 fwd_sel", 32'(s2_fwd), 32'hF);
        cycle(1'b0, lw(5'd7, 5'd1), 1'b0, 1'b0);
        chk("lat2 stall_cnt", 32'(s2_cnt), 32'd2);
        cycle(1'b0, dep, 1'b0, 1'b0);
        cycle(1'b0, dep, 1'b0, 1'b0);
        chk("sat reach", 32'(s2_cnt), 32'd3);
        cycle(1'b0, dep, 1'b0, 1'b0);
        chk("sat hold", 32'(s2_cnt), 32'd3);
        chk("sat fwd_sel", 32'(s2_fwd), 32'hF);

        // Randomised traffic over a small register set to provoke hazards.
        cycle(1'b1, nop, 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            instr_t r;
            logic rst;
            r = mk(($urandom_range(0, 7) != 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            rst = ($urandom_range(0, 79) == 0);
            cycle(rst, r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
